my_uart_rx: RTL and testbench

- UART 8N1 receiver, host -> FPGA direction; the counterpart of the existing FIFO-fed transmitter.
- Oversamples rs_rx at 16x with majority voting and checks the stop bit.
- Buffers received bytes in a small show-ahead FIFO with an rd_en/empty read port, mirroring the transmitter's read side.
- Consumers (command decode for start flag and channel select) pop bytes at their own pace.

---
 rtl/my_uart_rx.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_my_uart_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/my_uart_rx.sv
`timescale 1ns/1ps
// my_uart_rx: UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined).
// rs_rx is synchronized and sampled at 16x the baud rate. Each bit is decided
// by a majority vote of the samples at tick indices 7, 8 and 9. Good bytes go
// into a show-ahead FIFO that the consumer drains with rd_en.
//
// Optional feature macro: UART_RX_PARITY_EN (adds even parity bit + parity_err).
//
// Ports:
//   clk        system clock
//   reset      synchronous reset, active-high
//   rs_rx      asynchronous serial input, idles high
//   rd_en      pop the FIFO head byte (ignored while empty)
//   ovr_clr    clear the sticky overrun flag
//   q          FIFO head byte, valid while empty=0
//   empty/full FIFO status
//   usedw      FIFO occupancy
//   frame_err  one-cycle pulse on a bad stop bit
//   overrun    sticky, a byte was dropped because the FIFO was full
//   parity_err one-cycle pulse on bad parity (UART_RX_PARITY_EN only)
//   busy       receiver FSM is not idle
module my_uart_rx #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rs_rx,
    input  logic                          rd_en,
    input  logic                          ovr_clr,
    output logic [7:0]                    q,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   usedw,
    output logic                          frame_err,
    output logic                          overrun,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    output logic                          busy
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * 16);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Input synchronizer; the third flop provides the falling-edge reference.
    logic r_sync1, r_sync2, r_sync3;
    logic w_rx_s, w_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= rs_rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rx_s = r_sync2;
    assign w_fall = r_sync3 & ~r_sync2;

    // FSM control signals.
    state_t r_state, w_state_next;
    logic   w_restart, w_shift_en, w_bit_inc, w_push, w_fe;
`ifdef UART_RX_PARITY_EN
    logic   w_pe, w_par_cap, w_par_bad;
    logic   r_par_bit;
`endif

    // Oversample divider and per-bit tick index, realigned on each start edge.
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_tick_idx;
    logic             w_tick, w_dec, w_end;

    assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_dec  = w_tick && (r_tick_idx == 4'd9);
    assign w_end  = w_tick && (r_tick_idx == 4'd15);

    always_ff @(posedge clk) begin
        if (reset || w_restart) begin
            r_div_cnt  <= '0;
            r_tick_idx <= '0;
        end else if (w_tick) begin
            r_div_cnt  <= '0;
            r_tick_idx <= r_tick_idx + 4'd1;
        end else begin
            r_div_cnt  <= r_div_cnt + DIV_W'(1);
        end
    end

    // Samples at ticks 7 and 8; the tick-9 sample is the live rx_s.
    logic r_s7, r_s8, w_maj;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s7 <= 1'b1;
            r_s8 <= 1'b1;
        end else if (w_tick) begin
            if (r_tick_idx == 4'd7) r_s7 <= w_rx_s;
            if (r_tick_idx == 4'd8) r_s8 <= w_rx_s;
        end
    end

    assign w_maj = (r_s7 & r_s8) | (r_s7 & w_rx_s) | (r_s8 & w_rx_s);

    // Data shift register (LSB first) and bit counter.
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_restart) r_bit_cnt <= '0;
            else if (w_bit_inc) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_shift_en) r_shift <= {w_maj, r_shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) r_par_bit <= 1'b0;
        else if (w_par_cap) r_par_bit <= w_maj;
    end

    // Even parity: data plus parity bit must XOR to 0.
    assign w_par_bad = ^{r_shift, r_par_bit};
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next state and control strobes.
    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_shift_en   = 1'b0;
        w_bit_inc    = 1'b0;
        w_push       = 1'b0;
        w_fe         = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_pe         = 1'b0;
        w_par_cap    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_next = S_START;
                    w_restart    = 1'b1;
                end
            end
            S_START: begin
                // A start bit that votes high mid-bit was a glitch.
                if (w_dec && w_maj) w_state_next = S_IDLE;
                else if (w_end)     w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_dec) w_shift_en = 1'b1;
                if (w_end) begin
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (w_dec) w_par_cap = 1'b1;
                if (w_end) w_state_next = S_STOP;
`else
                w_state_next = S_IDLE;
`endif
            end
            S_STOP: begin
                // Leave at the decision tick so a back-to-back start edge is caught.
                if (w_dec) begin
                    w_state_next = S_IDLE;
                    if (!w_maj) w_fe = 1'b1;
`ifdef UART_RX_PARITY_EN
                    else if (w_par_bad) w_pe = 1'b1;
`endif
                    else w_push = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Registered status pulses.
    logic r_busy, r_frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_busy      <= (w_state_next != S_IDLE);
            r_frame_err <= w_fe;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge clk) begin
        if (reset) r_parity_err <= 1'b0;
        else       r_parity_err <= w_pe;
    end

    assign parity_err = r_parity_err;
`endif

    // Show-ahead receive FIFO.
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count, w_count_next;
    logic          r_empty, r_full, r_overrun;
    logic          w_pop, w_wr, w_ovf;

    assign w_pop        = rd_en & ~r_empty;
    assign w_wr         = w_push & (~r_full | w_pop);
    assign w_ovf        = w_push & r_full & ~w_pop;
    assign w_count_next = r_count + CW'(w_wr) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= 8'h00;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == CW'(FIFO_DEPTH));
        end
    end

    // A new overflow wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset)        r_overrun <= 1'b0;
        else if (w_ovf)   r_overrun <= 1'b1;
        else if (ovr_clr) r_overrun <= 1'b0;
    end

    assign q         = r_mem[r_rd_ptr];
    assign empty     = r_empty;
    assign full      = r_full;
    assign usedw     = r_count;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule

// File: tb/tb_my_uart_rx.sv
`timescale 1ns/1ps
// tb_my_uart_rx: directed bench for my_uart_rx at 115200 baud on a 50 MHz clock.
// Expected bytes are queued when a frame is sent and compared when popped.
module tb_my_uart_rx;

    localparam int unsigned CLK_FREQ = 50000000;
    localparam int unsigned BAUD     = 115200;
    localparam int unsigned DEPTH    = 4;
    localparam int          DIV      = 27;
    localparam int          BIT_CLKS = 16 * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int          PAR_BITS = 1;
`else
    localparam int          PAR_BITS = 0;
`endif
    // Start edge to empty falling: sync + edge detect, then the stop-bit decision tick.
    localparam int          LAT      = 3 + DIV * (154 + 16 * PAR_BITS);

    logic       clk, reset, rs_rx, rd_en, ovr_clr;
    logic [7:0] q;
    logic       empty, full, frame_err, overrun, busy;
    logic [$clog2(DEPTH):0] usedw;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    my_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_rx     (rs_rx),
        .rd_en     (rd_en),
        .ovr_clr   (ovr_clr),
        .q         (q),
        .empty     (empty),
        .full      (full),
        .usedw     (usedw),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         lat = 0;
    int         fe0, pe0;
    logic [7:0] sb [$];

    // Count status pulses as they happen.
    always @(posedge clk) begin
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
`endif
    end

    initial begin
        #(150000 * 20);
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rs_rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_b);
        rs_rx = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par_b);
        drive_bit(1'b1);
    endtask
`endif

    // Compare the FIFO head against the scoreboard, then pop it.
    task automatic pop_check(input string tag);
        logic [7:0] exp;
        chk({tag, "_empty"}, 32'(empty), 32'(0));
        chk({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk({tag, "_q"}, 32'(q), 32'(exp));
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        rs_rx = 1'b1; rd_en = 1'b0; ovr_clr = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_q",         32'(q),         32'(0));
        chk("rst_empty",     32'(empty),     32'(1));
        chk("rst_full",      32'(full),      32'(0));
        chk("rst_usedw",     32'(usedw),     32'(0));
        chk("rst_frame_err", 32'(frame_err), 32'(0));
        chk("rst_overrun",   32'(overrun),   32'(0));
        chk("rst_busy",      32'(busy),      32'(0));
        reset = 1'b0;
        idle(20);

        // Single byte: latency, content, pop.
        sb.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                lat = 0;
                while (empty && lat < 6000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        chk("a5_latency_window", 32'(lat >= LAT - DIV && lat <= LAT + DIV), 32'(1));
        chk("a5_usedw",     32'(usedw),  32'(1));
        chk("a5_frame_err", 32'(fe_cnt), 32'(0));
        pop_check("a5");
        chk("a5_empty_after_pop", 32'(empty), 32'(1));
        chk("a5_usedw_after_pop", 32'(usedw), 32'(0));
        idle(BIT_CLKS);

        // 60-clock glitch is rejected.
        rs_rx = 1'b0;
        idle(10);
        chk("glitch_busy_rise", 32'(busy), 32'(1));
        idle(50);
        rs_rx = 1'b1;
        idle(400);
        chk("glitch_busy_fall", 32'(busy),   32'(0));
        chk("glitch_empty",     32'(empty),  32'(1));
        chk("glitch_no_fe",     32'(fe_cnt), 32'(0));

        // Bad stop bit, then a clean frame.
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        idle(BIT_CLKS);
        chk("stop0_fe_pulses", 32'(fe_cnt - fe0), 32'(1));
        chk("stop0_empty",     32'(empty),        32'(1));
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        idle(10);
        pop_check("after_fe_11");
        chk("after_fe_no_extra_fe", 32'(fe_cnt - fe0), 32'(1));
        idle(BIT_CLKS);

        // Five back-to-back bytes into a 4-deep FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            if (i <= 4) sb.push_back(8'(i));
        end
        idle(10);
        chk("ovf_full",    32'(full),    32'(1));
        chk("ovf_usedw",   32'(usedw),   32'(4));
        chk("ovf_q_head",  32'(q),       32'(8'h01));
        chk("ovf_overrun", 32'(overrun), 32'(1));
        for (int i = 0; i < 4; i++) pop_check("ovf_pop");
        chk("ovf_drained", 32'(empty), 32'(1));
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'(0));
        idle(BIT_CLKS);

        // Reset in the middle of bit 4 with two bytes buffered.
        sb.push_back(8'h21);
        send_frame(8'h21, 1'b1);
        sb.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        chk("pre_rst_usedw", 32'(usedw), 32'(2));
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        idle(BIT_CLKS / 2);
        chk("pre_rst_busy", 32'(busy), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_empty", 32'(empty), 32'(1));
        chk("midrst_usedw", 32'(usedw), 32'(0));
        chk("midrst_busy",  32'(busy),  32'(0));
        reset = 1'b0;
        rs_rx = 1'b1;
        sb.delete();
        idle(2 * BIT_CLKS);
        sb.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        idle(10);
        pop_check("post_rst_7e");
        chk("post_rst_usedw", 32'(usedw), 32'(0));

`ifdef UART_RX_PARITY_EN
        // 0x03 has even data parity; parity bit 1 is wrong, 0 is right.
        idle(BIT_CLKS);
        pe0 = pe_cnt;
        fe0 = fe_cnt;
        send_frame_par(8'h03, 1'b1);
        idle(10);
        chk("par_bad_pulse", 32'(pe_cnt - pe0), 32'(1));
        chk("par_bad_empty", 32'(empty),        32'(1));
        chk("par_bad_no_fe", 32'(fe_cnt - fe0), 32'(0));
        sb.push_back(8'h03);
        send_frame_par(8'h03, 1'b0);
        idle(10);
        pop_check("par_good");
        chk("par_good_no_pe", 32'(pe_cnt - pe0), 32'(1));
`else
        pe0 = pe_cnt;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
